fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5: register address width.
REQ-002 Parameter DEPTH, default 3: in-flight writeback stages tracked, legal 1..7.
REQ-003 Parameter NSRC, default 2: source operands checked per cycle.
REQ-004 Derived SELW = clog2(DEPTH+1), 2 at defaults.
REQ-005 clk_i  input  1: single clock, all state rising-edge.
REQ-006 rst_i  input  1: synchronous, active-high reset.
REQ-007 issue_valid_i  input  1: instruction presented in decode.
REQ-008 issue_regwrite_i  input  1: presented instruction writes a register.
REQ-009 issue_rd_i  input  REG_AW: destination register.
REQ-010 issue_lat_i  input  SELW: stage at which result becomes forwardable, 1..DEPTH.
REQ-011 src_i  input  NSRC*REG_AW: packed source registers; source n at bits [n*REG_AW +: REG_AW].
REQ-012 advance_i  input  1: pipeline advances this cycle.
REQ-013 flush_i  input  1: squash all in-flight entries.
REQ-014 fwd_sel_o  output  NSRC*SELW: per source, 0 = register file, k = forward from stage k.
REQ-015 stall_o  output  1: decode must hold.
REQ-016 stall_cnt_o  output  16: stall-cycle count (see Configuration).

Function
REQ-017 SHALL hold DEPTH entries, stage 1 (youngest) to DEPTH (oldest); each holds valid, rd, lat.
REQ-018 On advance_i with flush_i low: entry[k+1] <= entry[k]; entry[DEPTH] retires; entry[1] loads the issue.
REQ-019 Issue loads valid only if issue_valid_i & issue_regwrite_i & issue_rd_i != 0 & !stall_o; otherwise bubble (valid=0).
REQ-020 advance_i low: all entries hold; no insertion.
REQ-021 flush_i high: all entries invalid at the next edge; priority over advance_i.
REQ-022 Entry at stage k matches source n when valid, rd == source n, source n != 0.
REQ-023 Only the youngest matching entry (lowest k) is considered per source.
REQ-024 Youngest match with k >= lat: fwd_sel_o[n] = k.
REQ-025 Youngest match with k < lat: fwd_sel_o[n] = 0, stall_o = 1.
REQ-026 No match, or source 0: fwd_sel_o[n] = 0.
REQ-027 stall_o = OR over sources of REQ-025; independent of issue_valid_i.
REQ-028 fwd_sel_o and stall_o combinational from entry state and src_i; zero-cycle latency.
REQ-029 issue_lat_i of 0 is treated as 1; above DEPTH is treated as DEPTH.

Reset
REQ-030 rst_i high at an edge: all entries invalid, stall_cnt_o = 0; priority over flush_i and advance_i.
REQ-031 Following reset: fwd_sel_o = 0, stall_o = 0 for any src_i.
REQ-032 Reset mid-stall: stall_o deasserts the cycle after the reset edge.

Configuration
REQ-033 Macro FWD_SCOREBOARD_STALL_CNT_EN defined: stall_cnt_o increments each cycle stall_o & advance_i are high, saturating at 16'hFFFF, cleared by rst_i only.
REQ-034 Macro undefined: port stall_cnt_o present, tied to 0, no counter logic.

Verification (DEPTH=3, NSRC=2, REG_AW=5)
REQ-035 Issue rd=5 lat=1, advance; next cycle src0=5 -> fwd_sel_o[0]=1, stall_o=0.
REQ-036 Issue rd=8 lat=2 (load), advance; src1=8 -> stall_o=1, bubble inserted; after one more advance -> fwd_sel_o[1]=2, stall_o=0.
REQ-037 Issue rd=3 twice back-to-back lat=1; src0=3 -> fwd_sel_o[0]=1 (youngest), not 2.
REQ-038 Issue rd=0 regwrite=1; src0=src1=0 -> fwd_sel_o=0, stall_o=0; three advances, nothing forwarded.
REQ-039 Stage 2 holds rd=9 lat=3, src0=9, flush_i=1 and advance_i=1 -> next cycle stall_o=0, fwd_sel_o=0.
REQ-040 With macro, 4 stall cycles with advance_i=1, then rst_i -> stall_cnt_o 4, then 0; without macro stall_cnt_o stays 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
// Tracks in-flight register writebacks across DEPTH pipeline stages. For each
// decode source operand it picks the youngest in-flight producer. If that
// result is already forwardable, it reports the forwarding stage. If the
// result is not ready yet, it raises stall.
//
// Optional feature: define FWD_SCOREBOARD_STALL_CNT_EN to build a saturating
// 16-bit counter of stalled advance cycles on stall_cnt_o. With the macro
// undefined, stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
   parameter  int REG_AW = 5,
   parameter  int DEPTH  = 3,
   parameter  int NSRC   = 2,
   localparam int SELW   = $clog2(DEPTH + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     issue_valid_i,
   input  logic                     issue_regwrite_i,
   input  logic [REG_AW-1:0]        issue_rd_i,
   input  logic [SELW-1:0]          issue_lat_i,
   input  logic [NSRC*REG_AW-1:0]   src_i,
   input  logic                     advance_i,
   input  logic                     flush_i,
   output logic [NSRC*SELW-1:0]     fwd_sel_o,
   output logic                     stall_o,
   output logic [15:0]              stall_cnt_o
);

   // Entry storage. Index k holds pipeline stage k+1, so index 0 is the youngest.
   logic                r_valid [DEPTH];
   logic [REG_AW-1:0]   r_rd    [DEPTH];
   logic [SELW-1:0]     r_lat   [DEPTH];

   // Per-source search results.
   logic [REG_AW-1:0]   w_src     [NSRC];
   logic                w_hit     [NSRC];
   logic [SELW-1:0]     w_hit_k   [NSRC];
   logic [SELW-1:0]     w_hit_lat [NSRC];

   logic [NSRC*SELW-1:0] w_fwd_sel;
   logic                 w_stall;
   logic [SELW-1:0]      w_issue_lat;
   logic                 w_issue_ok;

   // Clamp the issued latency into the legal stage range 1..DEPTH.
   always_comb begin
      w_issue_lat = issue_lat_i;
      if (issue_lat_i == {SELW{1'b0}}) begin
         w_issue_lat = SELW'(1);
      end else if (issue_lat_i > SELW'(DEPTH)) begin
         w_issue_lat = SELW'(DEPTH);
      end else begin
         w_issue_lat = issue_lat_i;
      end
   end

   // Only a real, non-x0 register write from an unstalled decode enters stage 1.
   always_comb begin
      w_issue_ok = issue_valid_i & issue_regwrite_i &
                   (issue_rd_i != {REG_AW{1'b0}}) & ~w_stall;
   end

   // Find the youngest matching entry per source. Scan oldest to youngest so the
   // lowest stage overwrites any older hit.
   always_comb begin
      for (int n = 0; n < NSRC; n++) begin
         w_src[n]     = src_i[n*REG_AW +: REG_AW];
         w_hit[n]     = 1'b0;
         w_hit_k[n]   = {SELW{1'b0}};
         w_hit_lat[n] = {SELW{1'b0}};
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && (r_rd[k] == w_src[n]) && (w_src[n] != {REG_AW{1'b0}})) begin
               w_hit[n]     = 1'b1;
               w_hit_k[n]   = SELW'(k + 1);
               w_hit_lat[n] = r_lat[k];
            end else begin
               w_hit[n]     = w_hit[n];
            end
         end
      end
   end

   // Turn each youngest hit into a forward select, or a stall when not yet ready.
   always_comb begin
      w_fwd_sel = {(NSRC*SELW){1'b0}};
      w_stall   = 1'b0;
      for (int n = 0; n < NSRC; n++) begin
         if (w_hit[n]) begin
            if (w_hit_k[n] >= w_hit_lat[n]) begin
               w_fwd_sel[n*SELW +: SELW] = w_hit_k[n];
            end else begin
               w_stall = 1'b1;
            end
         end else begin
            w_fwd_sel[n*SELW +: SELW] = {SELW{1'b0}};
         end
      end
   end

   // Drive the lookup results straight to the outputs, with zero-cycle latency.
   always_comb begin
      fwd_sel_o = w_fwd_sel;
      stall_o   = w_stall;
   end

   // Entry pipeline. Reset beats flush, flush beats advance, and with neither
   // the entries hold. On advance the oldest entry retires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_valid[k] <= 1'b0;
            r_rd[k]    <= {REG_AW{1'b0}};
            r_lat[k]   <= {SELW{1'b0}};
         end
      end else if (flush_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_valid[k] <= 1'b0;
         end
      end else if (advance_i) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            r_valid[k] <= r_valid[k-1];
            r_rd[k]    <= r_rd[k-1];
            r_lat[k]   <= r_lat[k-1];
         end
         r_valid[0] <= w_issue_ok;
         r_rd[0]    <= w_issue_ok ? issue_rd_i : {REG_AW{1'b0}};
         r_lat[0]   <= w_issue_lat;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            r_valid[k] <= r_valid[k];
         end
      end
   end

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Count the cycles in which the pipe advances while decode is stalled.
   // The count saturates at all-ones and only reset clears it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= 16'h0000;
      end else if (w_stall && advance_i && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   // Expose the stall count.
   always_comb begin
      stall_cnt_o = r_stall_cnt;
   end
`else
   // The counter is not built, so the port reads zero.
   always_comb begin
      stall_cnt_o = 16'h0000;
   end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_scoreboard
// Directed scenarios followed by randomized traffic. The results are compared
// against a queue-based reference model of the in-flight writebacks.
// ---------------------------------------------------------------------------
module tb_fwd_scoreboard;

   localparam int REG_AW = 5;
   localparam int DEPTH  = 3;
   localparam int NSRC   = 2;
   localparam int SELW   = 2;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   issue_valid_i;
   logic                   issue_regwrite_i;
   logic [REG_AW-1:0]      issue_rd_i;
   logic [SELW-1:0]        issue_lat_i;
   logic [NSRC*REG_AW-1:0] src_i;
   logic                   advance_i;
   logic                   flush_i;
   logic [NSRC*SELW-1:0]   fwd_sel_o;
   logic                   stall_o;
   logic [15:0]            stall_cnt_o;

   fwd_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .issue_valid_i    (issue_valid_i),
      .issue_regwrite_i (issue_regwrite_i),
      .issue_rd_i       (issue_rd_i),
      .issue_lat_i      (issue_lat_i),
      .src_i            (src_i),
      .advance_i        (advance_i),
      .flush_i          (flush_i),
      .fwd_sel_o        (fwd_sel_o),
      .stall_o          (stall_o),
      .stall_cnt_o      (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // The reference model holds one record per stage. Element 0 is stage 1.
   typedef struct {
      bit v;
      int rd;
      int lat;
   } ent_t;

   ent_t pipe_q[$];
   int   model_cnt_s;
   int   n_tests_s;
   int   n_fail_s;
   int   exp_sel_s;
   bit   exp_stall_s;

   // Compare one observed value with its expected value and report any mismatch.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests_s++;
      if (got !== exp) begin
         n_fail_s++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Apply one set of inputs.
   task automatic drive(input bit iv, input bit rw, input int rd, input int lat,
                        input int s0, input int s1, input bit adv, input bit fl, input bit rst);
      issue_valid_i    = iv;
      issue_regwrite_i = rw;
      issue_rd_i       = REG_AW'(rd);
      issue_lat_i      = SELW'(lat);
      src_i            = {REG_AW'(s1), REG_AW'(s0)};
      advance_i        = adv;
      flush_i          = fl;
      rst_i            = rst;
   endtask

   // Compute the expected outputs from the model state and the current sources.
   task automatic model_eval();
      int s;
      int sel;
      exp_sel_s   = 0;
      exp_stall_s = 1'b0;
      for (int n = 0; n < NSRC; n++) begin
         s   = int'(src_i[n*REG_AW +: REG_AW]);
         sel = 0;
         if (s != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (pipe_q[k].v && pipe_q[k].rd == s) begin
                  if (k + 1 >= pipe_q[k].lat) sel = k + 1;
                  else exp_stall_s = 1'b1;
                  break;
               end
            end
         end
         exp_sel_s = exp_sel_s | (sel << (n * SELW));
      end
   endtask

   // Let the inputs settle away from the clock edge, then compare all outputs.
   task automatic settle_check(input string tag);
      int exp_cnt;
      #4;
      model_eval();
      exp_cnt = 0;
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
      exp_cnt = model_cnt_s;
`endif
      check_eq({tag, "_sel"},   32'(fwd_sel_o),   32'(exp_sel_s));
      check_eq({tag, "_stall"}, 32'(stall_o),     32'(exp_stall_s));
      check_eq({tag, "_cnt"},   32'(stall_cnt_o), 32'(exp_cnt));
   endtask

   // Take a clock edge and move the reference model forward by one cycle.
   task automatic tick();
      ent_t e;
      int   lat;
      model_eval();
      @(posedge clk_i);
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) pipe_q[k].v = 1'b0;
         model_cnt_s = 0;
      end else begin
         if (exp_stall_s && advance_i && model_cnt_s < 65535) model_cnt_s++;
         if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k].v = 1'b0;
         end else if (advance_i) begin
            lat  = int'(issue_lat_i);
            lat  = (lat < 1) ? 1 : ((lat > DEPTH) ? DEPTH : lat);
            e.v  = issue_valid_i && issue_regwrite_i && (issue_rd_i != 0) && !exp_stall_s;
            e.rd = int'(issue_rd_i);
            e.lat = lat;
            void'(pipe_q.pop_back());
            pipe_q.push_front(e);
         end
      end
      #1;
   endtask

   initial begin
      ent_t z;
      n_tests_s   = 0;
      n_fail_s    = 0;
      model_cnt_s = 0;
      z.v = 1'b0; z.rd = 0; z.lat = 1;
      for (int k = 0; k < DEPTH; k++) pipe_q.push_back(z);

      // Reset
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
      settle_check("after_reset");
      check_eq("after_reset_sel_const", 32'(fwd_sel_o), 32'd0);

      // A lat=1 producer is forwarded from stage 1.
      drive(1, 1, 5, 1, 0, 0, 1, 0, 0); settle_check("r35_issue"); tick();
      drive(0, 0, 0, 0, 5, 0, 0, 0, 0); settle_check("r35_use");
      check_eq("r35_sel_const", 32'(fwd_sel_o), 32'h1);
      check_eq("r35_stall_const", 32'(stall_o), 32'h0);
      tick();

      // Load-use: stall once and insert a bubble, then forward from stage 2.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      drive(1, 1, 8, 2, 0, 0, 1, 0, 0); settle_check("r36_issue"); tick();
      drive(1, 1, 4, 1, 0, 8, 1, 0, 0); settle_check("r36_stall");
      check_eq("r36_stall_const", 32'(stall_o), 32'h1);
      tick();
      drive(0, 0, 0, 0, 0, 8, 0, 0, 0); settle_check("r36_fwd");
      check_eq("r36_sel_const", 32'(fwd_sel_o), 32'h8);
      check_eq("r36_nostall_const", 32'(stall_o), 32'h0);
      tick();

      // Two back-to-back writers of the same register: the youngest wins.
      drive(1, 1, 3, 1, 0, 0, 1, 0, 0); tick();
      drive(1, 1, 3, 1, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 3, 0, 0, 0, 0); settle_check("r37_young");
      check_eq("r37_sel_const", 32'(fwd_sel_o), 32'h1);
      tick();

      // Writes to register 0 are never tracked.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      drive(1, 1, 0, 1, 0, 0, 1, 0, 0); settle_check("r38_issue"); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0, 0); settle_check("r38_adv");
         check_eq("r38_sel_const", 32'(fwd_sel_o), 32'h0);
         tick();
      end

      // Flush beats advance and clears a pending stall.
      drive(1, 1, 9, 3, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 9, 0, 1, 1, 0); settle_check("r39_pre");
      check_eq("r39_pre_stall_const", 32'(stall_o), 32'h1);
      tick();
      drive(0, 0, 0, 0, 9, 0, 0, 0, 0); settle_check("r39_post");
      check_eq("r39_post_stall_const", 32'(stall_o), 32'h0);
      tick();

      // Four stalled advance cycles, then reset.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      for (int r = 0; r < 2; r++) begin
         drive(1, 1, 9, 3, 0, 0, 1, 0, 0); tick();
         drive(0, 0, 0, 0, 9, 0, 1, 0, 0); settle_check("r40_s1"); tick();
         drive(0, 0, 0, 0, 9, 0, 1, 0, 0); settle_check("r40_s2"); tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle_check("r40_cnt");
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
      check_eq("r40_cnt_const", 32'(stall_cnt_o), 32'd4);
`else
      check_eq("r40_cnt_const", 32'(stall_cnt_o), 32'd0);
`endif
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle_check("r40_cleared");
      check_eq("r40_cleared_const", 32'(stall_cnt_o), 32'd0);
      tick();

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 1) == 1,
               $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 6)),
               int'($urandom_range(0, 6)),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 99) == 0);
         settle_check("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests_s, n_fail_s);
      $finish;
   end

endmodule
